nway_dcache: RTL and testbench

//  Parametrised N-way set-associative, write-through, no-write-allocate data cache.

---
 rtl/nway_dcache_if.sv | 52 +++++
 rtl/nway_dcache.sv | 208 ++++++++++++++++++++
 tb/tb_nway_dcache.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nway_dcache_if.sv
// ---------------------------------------------------------------------------
// nway_dcache_if
//   Bus bundle for nway_dcache. It carries the CPU valid/ready request port,
//   the flush strobe, the multi-cycle req/ack memory port and the performance
//   counters.
//   Modports:
//     slave  : the cache side (takes CPU requests, drives the memory port)
//     master : the environment side (LSU plus data memory)
//   Signals:
//     cpu_valid/cpu_we/cpu_addr/cpu_wdata/cpu_be  request, held until cpu_ready
//     cpu_ready/cpu_rdata/cpu_hit                 completion, load data, hit flag
//     flush                                       invalidate every line
//     mem_req/mem_we/mem_addr/mem_wdata/mem_be    memory request, held until ack
//     mem_ack/mem_rdata                           one-cycle completion + read data
//     perf_accesses/perf_hits/perf_misses         request counters
// ---------------------------------------------------------------------------
interface nway_dcache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_valid;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [3:0]            cpu_be;
    logic                  cpu_ready;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_hit;
    logic                  flush;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [31:0]           perf_accesses;
    logic [31:0]           perf_hits;
    logic [31:0]           perf_misses;

    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_be, flush, mem_ack, mem_rdata,
        output cpu_ready, cpu_rdata, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               perf_accesses, perf_hits, perf_misses
    );

    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_be, flush, mem_ack, mem_rdata,
        input  cpu_ready, cpu_rdata, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               perf_accesses, perf_hits, perf_misses
    );
endinterface

// File: rtl/nway_dcache.sv
// ---------------------------------------------------------------------------
// nway_dcache
//   N-way set-associative, write-through, no-write-allocate data cache with
//   one word per line. Loads that hit complete in the request cycle; load
//   misses fetch from memory and fill the lowest invalid way, otherwise the
//   per-set round-robin victim. Stores always write through and update the
//   cached copy only when they hit.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; abandons any open transaction
//     bus    nway_dcache_if.slave (CPU port, flush, memory port, counters)
//   Optional feature macro: NWAY_DCACHE_PERF_EN enables the 32-bit
//   access/hit/miss counters; without it the perf outputs are tied to 0.
// ---------------------------------------------------------------------------
module nway_dcache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 4
) (
    input logic          clk,
    input logic          rst_n,
    nway_dcache_if.slave bus
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int TAG_W = ADDR_WIDTH - SET_W - 2;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t                state;
    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [WAY_W-1:0]      rr_q    [NUM_SETS];
    logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];
    logic                  wr_hit_q;
    logic [WAY_W-1:0]      wr_way_q;

    // Lookup side indexes with the live CPU address (only used in IDLE).
    logic [SET_W-1:0]    lk_set;
    logic [TAG_W-1:0]    lk_tag;
    logic [NUM_WAYS-1:0] hit_vec;
    logic [WAY_W-1:0]    hit_way;
    logic                lk_hit;
    logic                idle_take;
    // Fill/write side indexes with the registered memory address, which is
    // stable for the whole transaction.
    logic [SET_W-1:0]    fl_set;
    logic [TAG_W-1:0]    fl_tag;
    logic [WAY_W-1:0]    victim;
    logic                found_inv;

    assign lk_set    = bus.cpu_addr[SET_W+1:2];
    assign lk_tag    = bus.cpu_addr[ADDR_WIDTH-1:SET_W+2];
    assign fl_set    = bus.mem_addr[SET_W+1:2];
    assign fl_tag    = bus.mem_addr[ADDR_WIDTH-1:SET_W+2];
    assign lk_hit    = |hit_vec;
    assign idle_take = (state == IDLE) && bus.cpu_valid && !bus.flush;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
                hit_vec[w] = 1'b1;
                hit_way    = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victim    = rr_q[fl_set];
        found_inv = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found_inv && !valid_q[fl_set][w]) begin
                victim    = WAY_W'(w);
                found_inv = 1'b1;
            end
        end
    end

    // Completion is combinational: a load hit finishes in its request cycle
    // and a miss or store finishes in the mem_ack cycle.
    always_comb begin
        bus.cpu_ready = 1'b0;
        bus.cpu_rdata = '0;
        bus.cpu_hit   = 1'b0;
        if (idle_take && !bus.cpu_we && lk_hit) begin
            bus.cpu_ready = 1'b1;
            bus.cpu_rdata = data_q[lk_set][hit_way];
            bus.cpu_hit   = 1'b1;
        end else if (state == RD_MISS && bus.mem_ack) begin
            bus.cpu_ready = 1'b1;
            bus.cpu_rdata = bus.mem_rdata;
        end else if (state == WR_THRU && bus.mem_ack) begin
            bus.cpu_ready = 1'b1;
            bus.cpu_hit   = wr_hit_q;
        end
    end

    // Control FSM with registered memory-port outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= 4'h0;
            wr_hit_q      <= 1'b0;
            wr_way_q      <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
                    end else if (bus.cpu_valid) begin
                        bus.mem_addr <= bus.cpu_addr & ~ADDR_WIDTH'(3);
                        if (bus.cpu_we) begin
                            state         <= WR_THRU;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= 1'b1;
                            bus.mem_wdata <= bus.cpu_wdata;
                            bus.mem_be    <= bus.cpu_be;
                            wr_hit_q      <= lk_hit;
                            wr_way_q      <= hit_way;
                        end else if (lk_hit) begin
                            rr_q[lk_set] <= hit_way + WAY_W'(1);
                        end else begin
                            state       <= RD_MISS;
                            bus.mem_req <= 1'b1;
                            bus.mem_we  <= 1'b0;
                            bus.mem_be  <= 4'hF;
                        end
                    end
                end
                RD_MISS: begin
                    if (bus.mem_ack) begin
                        valid_q[fl_set][victim] <= 1'b1;
                        rr_q[fl_set]            <= victim + WAY_W'(1);
                        bus.mem_req             <= 1'b0;
                        state                   <= IDLE;
                    end
                end
                WR_THRU: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: tag and data arrays are not reset; valid_q alone decides whether
    // their contents mean anything, and skipping the reset keeps them as RAM.
    always_ff @(posedge clk) begin
        if (state == RD_MISS && bus.mem_ack) begin
            tag_q[fl_set][victim]  <= fl_tag;
            data_q[fl_set][victim] <= bus.mem_rdata;
        end
        if (state == WR_THRU && bus.mem_ack && wr_hit_q) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_be[b]) data_q[fl_set][wr_way_q][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

`ifdef NWAY_DCACHE_PERF_EN
    logic [31:0] acc_q, hits_q, misses_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            hits_q   <= '0;
            misses_q <= '0;
        end else if (bus.cpu_ready) begin
            acc_q <= acc_q + 32'd1;
            if (bus.cpu_hit) hits_q   <= hits_q + 32'd1;
            else             misses_q <= misses_q + 32'd1;
        end
    end

    assign bus.perf_accesses = acc_q;
    assign bus.perf_hits     = hits_q;
    assign bus.perf_misses   = misses_q;
`else
    assign bus.perf_accesses = '0;
    assign bus.perf_hits     = '0;
    assign bus.perf_misses   = '0;
`endif

    // Two valid ways of one set holding the same tag is a corrupted cache.
    a_single_hit: assert property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE && bus.cpu_valid) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_nway_dcache.sv
// ---------------------------------------------------------------------------
// tb_nway_dcache
//   Directed bench for nway_dcache (4 sets x 4 ways). A behavioural memory
//   responder acks mem_req after mem_lat idle cycles and keeps a sparse word
//   model; each test task drives requests and compares against hand-derived
//   expectations. Perf counters are checked against bench-side tallies when
//   NWAY_DCACHE_PERF_EN is defined, otherwise against zero.
// ---------------------------------------------------------------------------
module tb_nway_dcache;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nway_dcache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    nway_dcache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SETS(4), .NUM_WAYS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_acc = 0, exp_hits = 0, exp_misses = 0;

    // Memory responder state.
    int          mem_lat  = 3;
    bit          hold     = 1'b0;
    bit          late_ack = 1'b0;
    int          resp_cnt = 0;
    int          txn_cnt  = 0;
    logic [31:0] merge_tmp;
    logic [31:0] w_addr, w_data, r_addr;
    logic [3:0]  w_be, r_be;
    logic [31:0] mem_model [logic [31:0]];

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                resp_cnt    = 0;
            end else if (late_ack) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'h1234_5678;
                late_ack      = 1'b0;
            end else if (bus.mem_req && !hold) begin
                if (resp_cnt == mem_lat) begin
                    bus.mem_ack = 1'b1;
                    resp_cnt    = 0;
                    txn_cnt++;
                    if (bus.mem_we) begin
                        w_addr    = bus.mem_addr;
                        w_data    = bus.mem_wdata;
                        w_be      = bus.mem_be;
                        merge_tmp = model_rd(bus.mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (bus.mem_be[b]) merge_tmp[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                        mem_model[bus.mem_addr] = merge_tmp;
                    end else begin
                        r_addr        = bus.mem_addr;
                        r_be          = bus.mem_be;
                        bus.mem_rdata = model_rd(bus.mem_addr);
                    end
                end else begin
                    resp_cnt++;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // One CPU request; returns what the DUT reported and the cycles to ready.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit exp_hit,
                          output logic [31:0] rdata, output logic hit, output int lat);
        bit done = 1'b0;
        rdata = 'x; hit = 1'bx; lat = -1;
        @(posedge clk); #1;
        bus.cpu_valid = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
        bus.cpu_wdata = wdata; bus.cpu_be = be;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.cpu_ready) begin
                rdata = bus.cpu_rdata; hit = bus.cpu_hit; lat = i; done = 1'b1;
            end
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL timeout addr=%h: no cpu_ready within 100 cycles", addr);
        end
        @(posedge clk); #1;
        bus.cpu_valid = 1'b0;
        exp_acc++;
        if (exp_hit) exp_hits++; else exp_misses++;
    endtask

    task automatic flush_pulse();
        @(posedge clk); #1; bus.flush = 1'b1;
        @(posedge clk); #1; bus.flush = 1'b0;
    endtask

    task automatic test_perf(input string tag);
        @(negedge clk);
`ifdef NWAY_DCACHE_PERF_EN
        n_vec++; if (bus.perf_accesses !== exp_acc) begin n_err++;
            $display("FAIL perf_accesses(%s): got %0d want %0d", tag, bus.perf_accesses, exp_acc); end
        n_vec++; if (bus.perf_hits !== exp_hits) begin n_err++;
            $display("FAIL perf_hits(%s): got %0d want %0d", tag, bus.perf_hits, exp_hits); end
        n_vec++; if (bus.perf_misses !== exp_misses) begin n_err++;
            $display("FAIL perf_misses(%s): got %0d want %0d", tag, bus.perf_misses, exp_misses); end
`else
        n_vec++; if ({bus.perf_accesses, bus.perf_hits, bus.perf_misses} !== 96'h0) begin n_err++;
            $display("FAIL perf_tied(%s): got %h/%h/%h want 0", tag,
                     bus.perf_accesses, bus.perf_hits, bus.perf_misses); end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++;
            $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        n_vec++; if ({bus.cpu_ready, bus.cpu_hit, bus.cpu_rdata} !== 34'h0) begin n_err++;
            $display("FAIL reset_cpu_out: got ready=%b hit=%b rdata=%h want 0", bus.cpu_ready, bus.cpu_hit, bus.cpu_rdata); end
        n_vec++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 69'h0) begin n_err++;
            $display("FAIL reset_mem_out: got we=%b addr=%h wdata=%h be=%h want 0", bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be); end
        rst_n = 1'b1;
        exp_acc = 0; exp_hits = 0; exp_misses = 0;
        test_perf("reset");
    endtask

    task automatic test_cold_load();
        logic [31:0] rd; logic h; int lat; int t0;
        mem_model[32'h100] = 32'hDEAD_BEEF;
        mem_lat = 3;
        access(1'b0, 32'h100, '0, 4'h0, 1'b0, rd, h, lat);
        n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL cold_rdata: got %h want deadbeef", rd); end
        n_vec++; if (h !== 1'b0) begin n_err++; $display("FAIL cold_hit: got %b want 0", h); end
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL cold_latency: got %0d want 4", lat); end
        n_vec++; if (r_addr !== 32'h100 || r_be !== 4'hF) begin n_err++;
            $display("FAIL cold_memreq: got addr=%h be=%h want 100/f", r_addr, r_be); end
        t0 = txn_cnt;
        access(1'b0, 32'h102, '0, 4'h0, 1'b1, rd, h, lat);
        n_vec++; if (rd !== 32'hDEAD_BEEF || h !== 1'b1) begin n_err++;
            $display("FAIL reload_hit: got rdata=%h hit=%b want deadbeef/1", rd, h); end
        n_vec++; if (lat !== 0) begin n_err++; $display("FAIL reload_latency: got %0d want 0", lat); end
        n_vec++; if (txn_cnt !== t0) begin n_err++; $display("FAIL reload_no_mem: got %0d mem txns want 0", txn_cnt - t0); end
        test_perf("cold");
    endtask

    task automatic test_replacement();
        int idx [15] = '{0, 1, 2, 3, 4, 0, 2, 3, 4, 0, 1, 2, 4, 3, 0};
        bit eh  [15] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0};
        logic [31:0] rd, a; logic h; int lat;
        mem_lat = 1;
        flush_pulse();
        for (int k = 0; k < 15; k++) begin
            a = 32'h400 + 32'(idx[k]) * 32'h10;
            access(1'b0, a, '0, 4'h0, eh[k], rd, h, lat);
            n_vec++; if (h !== eh[k] || rd !== model_rd(a) || lat !== (eh[k] ? 0 : 2)) begin n_err++;
                $display("FAIL repl_step%0d addr=%h: got hit=%b rdata=%h lat=%0d want hit=%b rdata=%h lat=%0d",
                         k, a, h, rd, lat, eh[k], model_rd(a), eh[k] ? 0 : 2); end
        end
        test_perf("replacement");
    endtask

    task automatic test_store_hit();
        logic [31:0] rd; logic h; int lat; int t0;
        mem_lat = 2;
        access(1'b0, 32'h100, '0, 4'h0, 1'b0, rd, h, lat);
        n_vec++; if (rd !== 32'hDEAD_BEEF || h !== 1'b0) begin n_err++;
            $display("FAIL st_prefill: got rdata=%h hit=%b want deadbeef/0", rd, h); end
        access(1'b1, 32'h100, 32'h0000_5500, 4'b0010, 1'b1, rd, h, lat);
        n_vec++; if (h !== 1'b1 || lat !== 3) begin n_err++;
            $display("FAIL st_hit: got hit=%b lat=%0d want 1/3", h, lat); end
        n_vec++; if (w_addr !== 32'h100 || w_be !== 4'b0010 || w_data !== 32'h0000_5500) begin n_err++;
            $display("FAIL st_memwrite: got addr=%h be=%b data=%h want 100/0010/00005500", w_addr, w_be, w_data); end
        access(1'b0, 32'h100, '0, 4'h0, 1'b1, rd, h, lat);
        n_vec++; if (rd !== 32'hDEAD_55EF || h !== 1'b1) begin n_err++;
            $display("FAIL st_merge: got rdata=%h hit=%b want dead55ef/1", rd, h); end
        t0 = txn_cnt;
        access(1'b1, 32'h100, 32'hFFFF_FFFF, 4'h0, 1'b1, rd, h, lat);
        n_vec++; if (txn_cnt !== t0 + 1 || w_be !== 4'h0) begin n_err++;
            $display("FAIL st_be0_issue: got txns=%0d be=%h want 1/0", txn_cnt - t0, w_be); end
        access(1'b0, 32'h100, '0, 4'h0, 1'b1, rd, h, lat);
        n_vec++; if (rd !== 32'hDEAD_55EF || h !== 1'b1) begin n_err++;
            $display("FAIL st_be0_nochange: got rdata=%h hit=%b want dead55ef/1", rd, h); end
        test_perf("store_hit");
    endtask

    task automatic test_store_miss();
        logic [31:0] rd; logic h; int lat;
        access(1'b1, 32'h202, 32'hCAFE_F00D, 4'hF, 1'b0, rd, h, lat);
        n_vec++; if (h !== 1'b0 || w_addr !== 32'h200) begin n_err++;
            $display("FAIL stm_write: got hit=%b addr=%h want 0/200", h, w_addr); end
        access(1'b0, 32'h200, '0, 4'h0, 1'b0, rd, h, lat);
        n_vec++; if (h !== 1'b0 || rd !== 32'hCAFE_F00D) begin n_err++;
            $display("FAIL stm_no_alloc: got hit=%b rdata=%h want 0/cafef00d", h, rd); end
        access(1'b0, 32'h200, '0, 4'h0, 1'b1, rd, h, lat);
        n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL stm_refill: got hit=%b want 1", h); end
        test_perf("store_miss");
    endtask

    task automatic test_flush();
        logic [31:0] rd; logic h; int lat;
        access(1'b0, 32'h300, '0, 4'h0, 1'b0, rd, h, lat);
        access(1'b0, 32'h300, '0, 4'h0, 1'b1, rd, h, lat);
        n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL fl_precached: got hit=%b want 1", h); end
        @(posedge clk); #1;
        bus.flush = 1'b1; bus.cpu_valid = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h300;
        @(negedge clk);
        n_vec++; if (bus.cpu_ready !== 1'b0) begin n_err++;
            $display("FAIL fl_wins: got cpu_ready=%b want 0", bus.cpu_ready); end
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.cpu_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++;
            $display("FAIL fl_no_req: got mem_req=%b want 0", bus.mem_req); end
        access(1'b0, 32'h300, '0, 4'h0, 1'b0, rd, h, lat);
        n_vec++; if (h !== 1'b0) begin n_err++; $display("FAIL fl_miss_300: got hit=%b want 0", h); end
        access(1'b0, 32'h100, '0, 4'h0, 1'b0, rd, h, lat);
        n_vec++; if (h !== 1'b0) begin n_err++; $display("FAIL fl_miss_100: got hit=%b want 0", h); end
        test_perf("flush");
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic h; int lat; bit seen = 1'b0;
        hold = 1'b1;
        @(posedge clk); #1;
        bus.cpu_valid = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h500;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_req;
        end
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL rm_req_seen: got %b want 1", seen); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.mem_req !== 1'b0 || bus.cpu_ready !== 1'b0) begin n_err++;
            $display("FAIL rm_async_drop: got mem_req=%b ready=%b want 0/0", bus.mem_req, bus.cpu_ready); end
        bus.cpu_valid = 1'b0;
        exp_acc = 0; exp_hits = 0; exp_misses = 0;
        @(negedge clk);
        rst_n = 1'b1;
        hold = 1'b0;
        late_ack = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.cpu_ready !== 1'b0 || bus.mem_req !== 1'b0) begin n_err++;
            $display("FAIL rm_late_ack: got ready=%b mem_req=%b want 0/0", bus.cpu_ready, bus.mem_req); end
        @(negedge clk);
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++;
            $display("FAIL rm_idle_after: got mem_req=%b want 0", bus.mem_req); end
        test_perf("reset_mid");
        access(1'b0, 32'h100, '0, 4'h0, 1'b0, rd, h, lat);
        n_vec++; if (h !== 1'b0) begin n_err++; $display("FAIL rm_empty_100: got hit=%b want 0", h); end
        access(1'b0, 32'h500, '0, 4'h0, 1'b0, rd, h, lat);
        n_vec++; if (h !== 1'b0 || rd !== model_rd(32'h500)) begin n_err++;
            $display("FAIL rm_empty_500: got hit=%b rdata=%h want 0/%h", h, rd, model_rd(32'h500)); end
        test_perf("after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_valid = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0;   bus.cpu_be = 4'h0; bus.flush = 1'b0;
        test_reset();
        test_cold_load();
        test_replacement();
        test_store_hit();
        test_store_miss();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
